// File: rtl/hilo_divider_pkg.sv
// hilo_divider_pkg: shared constants for the Hi/Lo divide unit.
//   - Function codes (DIVU, MULTU, MFHI, MFLO). The ALU result mux uses these too.
//   - FSM state encoding.
//   - Default datapath width.
package hilo_divider_pkg;

  localparam int unsigned DefaultWidth = 32;

  localparam logic [5:0] FnMfhi  = 6'b010000;
  localparam logic [5:0] FnMflo  = 6'b010010;
  localparam logic [5:0] FnMultu = 6'b011001;
  localparam logic [5:0] FnDivu  = 6'b011011;

  // StDiv is also the shared run state when multiply support is compiled in.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StDiv  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/hilo_divider_div_step.sv
// hilo_divider_div_step: one combinational restoring-division iteration.
// Ports:
//   rem_i       current partial remainder
//   quot_i      current shift register (dividend bits not yet consumed / quotient bits)
//   divisor_i   divisor
//   rem_o       remainder after this iteration
//   quot_o      shift register after this iteration (new quotient bit in LSB)
module hilo_divider_div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quot_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quot_o
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;
  logic             borrow;

  always_comb begin
    // WIDTH+1 bits hold the bit shifted out of rem; one extra bit exposes the borrow.
    shifted = {rem_i, quot_i[WIDTH-1]};
    trial   = {1'b0, shifted} - {2'b00, divisor_i};
    borrow  = trial[WIDTH+1];
    // Without a borrow the difference is below the divisor, so it fits in WIDTH bits.
    rem_o   = borrow ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    quot_o  = {quot_i[WIDTH-2:0], ~borrow};
  end

endmodule

// File: rtl/hilo_divider.sv
// hilo_divider: multi-cycle unsigned divide unit owning the Hi/Lo registers.
// DIVU starts a restoring division, one quotient bit per cycle. On completion
// Hi = remainder, Lo = quotient; both hold until the next completed operation.
// Optional macro HILO_MULTU_EN adds MULTU (shift-add multiply, same latency,
// Hi/Lo = upper/lower product halves).
// Ports:
//   clk     clock, rising edge
//   reset   synchronous active-high reset
//   dataA   dividend / multiplicand source (rs)
//   dataB   divisor / multiplier source (rt)
//   Signal  function code
//   HiOut   Hi register
//   LoOut   Lo register
//   busy    operation in flight
//   done    one-cycle pulse after Hi/Lo update
module hilo_divider
  import hilo_divider_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  input  logic [5:0]       Signal,
  output logic [WIDTH-1:0] HiOut,
  output logic [WIDTH-1:0] LoOut,
  output logic             busy,
  output logic             done
);

  state_e state_q, state_d;

  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic             start;
  logic             last_iter;
  logic [WIDTH-1:0] step_rem, step_quot;
  logic [WIDTH-1:0] div_rem, div_quot;

  hilo_divider_div_step #(
    .WIDTH (WIDTH)
  ) u_div_step (
    .rem_i     (rem_q),
    .quot_i    (quot_q),
    .divisor_i (divisor_q),
    .rem_o     (div_rem),
    .quot_o    (div_quot)
  );

`ifdef HILO_MULTU_EN
  logic           mul_q, mul_d;
  logic [WIDTH:0] mul_sum;

  assign start = (Signal == FnDivu) || (Signal == FnMultu);

  // Shift-add: rem holds the running upper half, quot shifts the multiplier out
  // of its LSB while product bits enter at its MSB.
  always_comb begin
    mul_sum = {1'b0, rem_q} + (quot_q[0] ? {1'b0, divisor_q} : '0);
    if (mul_q) begin
      step_rem  = mul_sum[WIDTH:1];
      step_quot = {mul_sum[0], quot_q[WIDTH-1:1]};
    end else begin
      step_rem  = div_rem;
      step_quot = div_quot;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mul_q <= 1'b0;
    end else begin
      mul_q <= mul_d;
    end
  end
`else
  assign start     = (Signal == FnDivu);
  assign step_rem  = div_rem;
  assign step_quot = div_quot;
`endif

  assign last_iter = (count_q == CNT_W'(WIDTH - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. Requests outside StIdle are dropped, not queued.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StDiv;
      StDiv:   if (last_iter) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from state.
  always_comb begin
    busy = (state_q == StDiv);
    done = (state_q == StDone);
  end

  // Datapath next-state. Hi/Lo change only on the final iteration, so an
  // abandoned operation never writes them.
  always_comb begin
    rem_d     = rem_q;
    quot_d    = quot_q;
    divisor_d = divisor_q;
    count_d   = count_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
`ifdef HILO_MULTU_EN
    mul_d     = mul_q;
`endif
    if ((state_q == StIdle) && start) begin
      rem_d     = '0;
      quot_d    = dataA;
      divisor_d = dataB;
      count_d   = '0;
`ifdef HILO_MULTU_EN
      mul_d     = (Signal == FnMultu);
`endif
    end else if (state_q == StDiv) begin
      rem_d   = step_rem;
      quot_d  = step_quot;
      count_d = count_q + CNT_W'(1);
      if (last_iter) begin
        hi_d = step_rem;
        lo_d = step_quot;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rem_q     <= '0;
      quot_q    <= '0;
      divisor_q <= '0;
      count_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      rem_q     <= rem_d;
      quot_q    <= quot_d;
      divisor_q <= divisor_d;
      count_q   <= count_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign HiOut = hi_q;
  assign LoOut = lo_q;

endmodule

// File: tb/tb_hilo_divider.sv
// Self-checking bench for hilo_divider: a vector table of single operations
// plus hand-written sequences for hold/ignore, reset mid-operation and
// reset colliding with a start.
module tb_hilo_divider;
  import hilo_divider_pkg::*;

  localparam int unsigned W = 32;

  logic         clk;
  logic         reset;
  logic [W-1:0] dataA;
  logic [W-1:0] dataB;
  logic [5:0]   Signal;
  logic [W-1:0] HiOut;
  logic [W-1:0] LoOut;
  logic         busy;
  logic         done;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] prev_hi;
  logic [W-1:0] prev_lo;

  hilo_divider #(
    .WIDTH (W),
    .CNT_W (6)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .dataA  (dataA),
    .dataB  (dataB),
    .Signal (Signal),
    .HiOut  (HiOut),
    .LoOut  (LoOut),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [5:0]   sig;
    logic         starts;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } vec_t;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation and, if it should start, wait for done and check
  // latency and results. Operands are scrambled right after the start edge.
  task automatic run_op(input vec_t v, input string name);
    int n;
    @(negedge clk);
    dataA  = v.a;
    dataB  = v.b;
    Signal = v.sig;
    tick();
    Signal = 6'b0;
    dataA  = ~v.a;
    dataB  = ~v.b;
    chk({name, ".busy_after_start"}, W'(busy), W'(v.starts));
    if (v.starts) begin
      n = 0;
      while (!done && n < 40) begin
        tick();
        n++;
      end
      chk({name, ".latency"}, W'(n), W'(32));
      chk({name, ".hi"}, HiOut, v.hi);
      chk({name, ".lo"}, LoOut, v.lo);
      chk({name, ".busy_at_done"}, W'(busy), W'(0));
      prev_hi = v.hi;
      prev_lo = v.lo;
      tick();
      chk({name, ".done_one_cycle"}, W'(done), W'(0));
    end else begin
      tick();
      chk({name, ".stays_idle"}, W'(busy), W'(0));
      chk({name, ".hi_unchanged"}, HiOut, prev_hi);
      chk({name, ".lo_unchanged"}, LoOut, prev_lo);
    end
  endtask

  vec_t vecs[8];

  initial begin
    int n;
    int seen_done;

    vecs[0] = '{a: 32'd100,        b: 32'd7,   sig: FnDivu, starts: 1'b1,
                hi: 32'd2,          lo: 32'd14};
    vecs[1] = '{a: 32'hFFFFFFFF,   b: 32'd1,   sig: FnDivu, starts: 1'b1,
                hi: 32'd0,          lo: 32'hFFFFFFFF};
    vecs[2] = '{a: 32'd5,          b: 32'd9,   sig: FnDivu, starts: 1'b1,
                hi: 32'd5,          lo: 32'd0};
    vecs[3] = '{a: 32'h00001234,   b: 32'd0,   sig: FnDivu, starts: 1'b1,
                hi: 32'h00001234,   lo: 32'hFFFFFFFF};
    vecs[4] = '{a: 32'hDEADBEEF,   b: 32'h10,  sig: FnDivu, starts: 1'b1,
                hi: 32'h0000000F,   lo: 32'h0DEADBEE};
    vecs[5] = '{a: 32'd7,          b: 32'd2,   sig: FnMfhi, starts: 1'b0,
                hi: 32'd0,          lo: 32'd0};
`ifdef HILO_MULTU_EN
    vecs[6] = '{a: 32'hFFFFFFFF,   b: 32'd2,   sig: FnMultu, starts: 1'b1,
                hi: 32'd1,          lo: 32'hFFFFFFFE};
`else
    vecs[6] = '{a: 32'hFFFFFFFF,   b: 32'd2,   sig: FnMultu, starts: 1'b0,
                hi: 32'd0,          lo: 32'd0};
`endif
    vecs[7] = '{a: 32'd1000,       b: 32'd1000, sig: FnDivu, starts: 1'b1,
                hi: 32'd0,          lo: 32'd1};

    reset  = 1'b1;
    dataA  = '0;
    dataB  = '0;
    Signal = 6'b0;
    prev_hi = '0;
    prev_lo = '0;
    tick();
    tick();
    chk("reset.hi", HiOut, '0);
    chk("reset.lo", LoOut, '0);
    chk("reset.busy", W'(busy), W'(0));
    chk("reset.done", W'(done), W'(0));
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i], $sformatf("vec%0d", i));
    end

    // Hold and ignore: old result stays visible while busy; a second DIVU mid-run is dropped.
    run_op(vecs[0], "hold.prime");
    @(negedge clk);
    dataA  = 32'd50;
    dataB  = 32'd5;
    Signal = FnDivu;
    tick();
    Signal = 6'b0;
    n = 0;
    while (!done && n < 40) begin
      if (n == 9) begin
        Signal = FnDivu;
        dataA  = 32'd9;
        dataB  = 32'd3;
      end
      tick();
      Signal = 6'b0;
      n++;
      if (!done) begin
        chk($sformatf("hold.hi_c%0d", n), HiOut, 32'd2);
        chk($sformatf("hold.lo_c%0d", n), LoOut, 32'd14);
      end
    end
    chk("hold.latency", W'(n), W'(32));
    chk("hold.hi", HiOut, 32'd0);
    chk("hold.lo", LoOut, 32'd10);
    seen_done = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done || busy) seen_done++;
    end
    chk("hold.second_req_dropped", W'(seen_done), W'(0));
    chk("hold.hi_kept", HiOut, 32'd0);
    chk("hold.lo_kept", LoOut, 32'd10);

    // Reset mid-operation.
    @(negedge clk);
    dataA  = 32'd100;
    dataB  = 32'd7;
    Signal = FnDivu;
    tick();
    Signal = 6'b0;
    for (int i = 0; i < 14; i++) tick();
    chk("midrst.busy_before", W'(busy), W'(1));
    @(negedge clk);
    reset = 1'b1;
    tick();
    chk("midrst.busy", W'(busy), W'(0));
    chk("midrst.done", W'(done), W'(0));
    chk("midrst.hi", HiOut, '0);
    chk("midrst.lo", LoOut, '0);
    @(negedge clk);
    reset = 1'b0;
    seen_done = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done || busy) seen_done++;
    end
    chk("midrst.no_late_done", W'(seen_done), W'(0));
    chk("midrst.lo_still_zero", LoOut, '0);

    // Reset and DIVU on the same edge: reset wins.
    @(negedge clk);
    reset  = 1'b1;
    dataA  = 32'd100;
    dataB  = 32'd7;
    Signal = FnDivu;
    tick();
    chk("rst_vs_divu.busy", W'(busy), W'(0));
    @(negedge clk);
    reset  = 1'b0;
    Signal = 6'b0;
    tick();
    chk("rst_vs_divu.still_idle", W'(busy), W'(0));

    // Unit is usable again after the reset.
    prev_hi = '0;
    prev_lo = '0;
    run_op(vecs[4], "post_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hilo_divider.md
Name: hilo_divider

Overview:
- Multi-cycle unsigned divide unit that owns the architectural Hi and Lo registers.
- It is the producer side of the HiOut/LoOut path that the ALU result mux selects for MFHI/MFLO.
- Starts on the DIVU function code and computes one quotient bit per cycle (restoring division).
- On completion it writes remainder to Hi and quotient to Lo, and holds them until the next operation.

Parameters:
- WIDTH, 32, operand/Hi/Lo width in bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- dataA  input  WIDTH  dividend (rs).
- dataB  input  WIDTH  divisor (rt).
- Signal  input  6  function code; DIVU = 6'b011011 starts an operation; all other codes are ignored.
- HiOut  output  WIDTH  Hi register (remainder).
- LoOut  output  WIDTH  Lo register (quotient).
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle pulse when Hi/Lo have just been updated.

Behaviour:
- Reset (synchronous, active-high), applied on the edge where reset=1:
  - HiOut=0, LoOut=0, busy=0, done=0, state=IDLE.
  - Any operation in flight is abandoned, with no partial write to Hi/Lo.
- States:
  - IDLE: if Signal==DIVU at edge N, capture dataA into the shift register, dataB into the divisor register, remainder=0, count=0. Go to DIV; busy=1 after edge N.
  - DIV: each edge shifts {rem,quot} left by 1 and trial-subtracts the divisor from rem[WIDTH:0].
    - No borrow: keep the difference and set quotient bit = 1.
    - Borrow: restore and set quotient bit = 0.
    - count increments; after WIDTH iterations (edge N+WIDTH) go to DONE.
  - DONE: on the transition into DONE, write HiOut=remainder and LoOut=quotient. busy=0 and done=1 for exactly one cycle. Next edge returns to IDLE.
  - Latency: results visible WIDTH cycles after the start edge (32 by default). Back-to-back starts are accepted one cycle after done.
- HiOut/LoOut hold their old values throughout DIV, so MFHI/MFLO during busy return the previous result.
- DIVU while busy or done is high is ignored and not queued; software/control must stall on busy.
- Divide-by-zero (dataB==0 at capture) takes the same latency and produces LoOut = all ones, HiOut = dataA. This falls out of the restoring algorithm and needs no special case.
- Arithmetic:
  - Trial subtract is WIDTH+1 bits wide to hold the carry.
  - Operands are unsigned; no overflow is possible.
- Simultaneous reset and DIVU: reset wins.
- Operands are sampled only at the start edge; later changes on dataA/dataB have no effect.

Optional Feature:
- Macro: HILO_MULTU_EN.
- Defined:
  - Signal==MULTU (6'b011001) in IDLE starts an unsigned shift-add multiply with the same WIDTH-cycle latency.
  - Result is the 2*WIDTH product: HiOut = upper half, LoOut = lower half.
  - busy/done behave as for DIVU.
  - State DIV is generalized to RUN with an op flag.
- Not defined: MULTU is ignored like any other non-DIVU code; no multiply datapath is synthesized.

Decomposition:
- Shared package holds:
  - Function-code constants DIVU, MULTU, MFHI, MFLO, also used by the ALU result mux.
  - State encoding IDLE/DIV/DONE as a 2-bit typedef.
  - Default WIDTH.
- One natural sub-module: div_step, a combinational single restoring iteration.
  - Inputs: rem, quot, divisor.
  - Outputs: next rem, next quot.
  - Lets the iteration be checked in isolation.

Test Plan:
- Basic divide: reset, then DIVU with dataA=100, dataB=7 -> busy high for 32 cycles, done pulse, LoOut=14, HiOut=2.
- Edge operands: dataA=32'hFFFFFFFF, dataB=1 -> LoOut=32'hFFFFFFFF, HiOut=0. Then dataA=5, dataB=9 -> LoOut=0, HiOut=5.
- Divide-by-zero: dataA=32'h1234, dataB=0 -> after 32 cycles LoOut=32'hFFFFFFFF, HiOut=32'h1234.
- Hold and ignore:
  - Previous result Hi=2/Lo=14; start 50/5, then pulse DIVU with 9/3 at cycle 10 of busy.
  - HiOut/LoOut read 2/14 until done, then 0/10. The second request has no effect.
- Reset mid-operation: assert reset at cycle 15 of a divide -> next cycle busy=0, done=0, HiOut=LoOut=0; no later done pulse.
- With HILO_MULTU_EN: MULTU with 32'hFFFFFFFF x 2 -> after 32 cycles HiOut=1, LoOut=32'hFFFFFFFE. Without the macro, the same stimulus -> busy stays 0.
